// File: rtl/gvp_pkg.sv
// Shared constants, frame sizing and serializer state type for the GVP store packer.
package gvp_pkg;

    localparam logic [3:0] TAG_HDR         = 4'h2;
    localparam logic [3:0] TAG_DATA        = 4'h1;
    localparam int         HDR_WORDS       = 32'd7;
    localparam int         DATA_BASE_WORDS = 32'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Number of 32-bit words in a header (is_hdr=1) or data frame.
    function automatic logic [3:0] frame_len(input logic is_hdr, input int num_src);
        if (is_hdr) begin
            return 4'(HDR_WORDS);
        end else begin
            return 4'(DATA_BASE_WORDS + num_src);
        end
    endfunction

endpackage

// File: rtl/gvp_frame_serializer.sv
// Shifts one buffered frame out on AXI4-Stream; reloads straight from the
// pending buffer on the final handshake so consecutive frames have no bubble.
module gvp_frame_serializer
    import gvp_pkg::*;
#(
    parameter int FRAME_WORDS = 9
) (
    input  logic                     a_clk,
    input  logic                     reset,
    input  logic                     pend_valid,
    input  logic [FRAME_WORDS*32-1:0] words_in,
    input  logic [3:0]               len_in,
    output logic                     take,
    output logic                     frame_done,
    output logic                     active,
    output logic [31:0]              M_AXIS_tdata,
    output logic                     M_AXIS_tvalid,
    output logic                     M_AXIS_tlast,
    input  logic                     M_AXIS_tready
);

    ser_state_e  state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic [3:0]  len_r;
    logic [31:0] tdata_r, tdata_s;
    logic        tvalid_r, tvalid_s;
    logic        tlast_r, tlast_s;
    logic        take_s, done_s, hs_s;
    logic [31:0] words_r [0:FRAME_WORDS-1];

    assign hs_s = tvalid_r & M_AXIS_tready;

    // Next-state, next-word and load decision.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        tdata_s  = tdata_r;
        tvalid_s = tvalid_r;
        tlast_s  = tlast_r;
        take_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_valid) begin
                    take_s   = 1'b1;
                    state_s  = SEND;
                    idx_s    = 4'd0;
                    tdata_s  = words_in[31:0];
                    tvalid_s = 1'b1;
                    tlast_s  = (len_in == 4'd1);
                end else begin
                    tvalid_s = 1'b0;
                    tlast_s  = 1'b0;
                end
            end
            SEND: begin
                if (hs_s && tlast_r) begin
                    done_s = 1'b1;
                    if (pend_valid) begin
                        take_s  = 1'b1;
                        idx_s   = 4'd0;
                        tdata_s = words_in[31:0];
                        tlast_s = (len_in == 4'd1);
                    end else begin
                        state_s  = IDLE;
                        tvalid_s = 1'b0;
                        tlast_s  = 1'b0;
                        tdata_s  = 32'h0000_0000;
                    end
                end else if (hs_s) begin
                    idx_s   = idx_r + 4'd1;
                    tdata_s = words_r[idx_r + 4'd1];
                    tlast_s = ((idx_r + 4'd2) == len_r);
                end else begin
                    // stalled: hold the presented word
                    tdata_s = tdata_r;
                end
            end
            default: begin
                state_s  = IDLE;
                idx_s    = 4'd0;
                tdata_s  = 32'h0000_0000;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
    end

    // State and registered AXIS outputs.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_r  <= IDLE;
            idx_r    <= 4'd0;
            len_r    <= 4'd0;
            tdata_r  <= 32'h0000_0000;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            tdata_r  <= tdata_s;
            tvalid_r <= tvalid_s;
            tlast_r  <= tlast_s;
            if (take_s) begin
                len_r <= len_in;
            end
        end
    end

    // Active shift buffer, filled from the pending buffer on each load.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            for (int k = 0; k < FRAME_WORDS; k++) begin
                words_r[k] <= 32'h0000_0000;
            end
        end else if (take_s) begin
            for (int k = 0; k < FRAME_WORDS; k++) begin
                words_r[k] <= words_in[k*32 +: 32];
            end
        end
    end

    assign take          = take_s;
    assign frame_done    = done_s;
    assign active        = (state_r == SEND);
    assign M_AXIS_tdata  = tdata_r;
    assign M_AXIS_tvalid = tvalid_r;
    assign M_AXIS_tlast  = tlast_r;

endmodule

// File: rtl/gvp_store_packer.sv
// Captures GVP store triggers into tagged frames, holds one pending frame,
// and hands frames to the AXIS serializer; counts drops and completed frames.
module gvp_store_packer
    import gvp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 32
) (
    input  logic                     a_clk,
    input  logic                     reset,
    input  logic                     store_strobe,
    input  logic [1:0]               store_data,
    input  logic [31:0]              section,
    input  logic [31:0]              options,
    input  logic [31:0]              index,
    input  logic [31:0]              x,
    input  logic [31:0]              y,
    input  logic [31:0]              z,
    input  logic [31:0]              u,
    input  logic [NUM_SRC*SRC_W-1:0] src_data,
    output logic [31:0]              M_AXIS_tdata,
    output logic                     M_AXIS_tvalid,
    output logic                     M_AXIS_tlast,
    input  logic                     M_AXIS_tready,
    output logic [15:0]              overflow_count,
    output logic [31:0]              frame_count,
    output logic                     busy
);

    localparam int DATA_WORDS  = DATA_BASE_WORDS + NUM_SRC;
    localparam int FRAME_WORDS = (DATA_WORDS > HDR_WORDS) ? DATA_WORDS : HDR_WORDS;

    logic                      trig_s, is_hdr_s, accept_s, take_s;
    logic                      frame_done_s, ser_active_s;
    logic                      pend_full_r;
    logic [FRAME_WORDS*32-1:0] words_s, pend_words_r;
    logic [3:0]                len_s, pend_len_r;
    logic [15:0]               sample_cnt_r, overflow_r;
    logic [31:0]               frames_r;
    logic                      unused_s;

    assign unused_s = ^section[31:16];
    assign trig_s   = store_strobe & ((store_data == 2'd1) | (store_data == 2'd2));
    assign is_hdr_s = (store_data == 2'd2);
    // a reload in the same cycle frees the pending slot for the new trigger
    assign accept_s = trig_s & (~pend_full_r | take_s);
    assign len_s    = frame_len(is_hdr_s, NUM_SRC);

    // Assemble the frame image for the current inputs.
    always_comb begin
        words_s = {(FRAME_WORDS*32){1'b0}};
        if (is_hdr_s) begin
            words_s[0*32 +: 32] = {TAG_HDR, 12'h000, section[15:0]};
            words_s[1*32 +: 32] = options;
            words_s[2*32 +: 32] = index;
            words_s[3*32 +: 32] = x;
            words_s[4*32 +: 32] = y;
            words_s[5*32 +: 32] = z;
            words_s[6*32 +: 32] = u;
        end else begin
            words_s[0*32 +: 32] = {TAG_DATA, 12'h000, sample_cnt_r};
            words_s[1*32 +: 32] = x;
            words_s[2*32 +: 32] = y;
            words_s[3*32 +: 32] = z;
            words_s[4*32 +: 32] = u;
            for (int k = 0; k < NUM_SRC; k++) begin
                words_s[(DATA_BASE_WORDS + k)*32 +: 32] = src_data[k*SRC_W +: SRC_W];
            end
        end
    end

    // Pending buffer, sample counter and status counters.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            pend_full_r  <= 1'b0;
            pend_words_r <= {(FRAME_WORDS*32){1'b0}};
            pend_len_r   <= 4'd0;
            sample_cnt_r <= 16'h0000;
            overflow_r   <= 16'h0000;
            frames_r     <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                pend_full_r  <= 1'b1;
                pend_words_r <= words_s;
                pend_len_r   <= len_s;
                sample_cnt_r <= is_hdr_s ? 16'h0000 : (sample_cnt_r + 16'h0001);
            end else if (take_s) begin
                pend_full_r <= 1'b0;
            end
            if (trig_s && !accept_s && (overflow_r != 16'hFFFF)) begin
                overflow_r <= overflow_r + 16'h0001;
            end
            if (frame_done_s) begin
                frames_r <= frames_r + 32'h0000_0001;
            end
        end
    end

    gvp_frame_serializer #(
        .FRAME_WORDS (FRAME_WORDS)
    ) u_ser (
        .a_clk         (a_clk),
        .reset         (reset),
        .pend_valid    (pend_full_r),
        .words_in      (pend_words_r),
        .len_in        (pend_len_r),
        .take          (take_s),
        .frame_done    (frame_done_s),
        .active        (ser_active_s),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tready (M_AXIS_tready)
    );

    assign overflow_count = overflow_r;
    assign frame_count    = frames_r;
    assign busy           = ser_active_s | pend_full_r;

endmodule
